ball_motion: RTL

BALL_MOTION -- requirements
Module: ball_motion

---
 rtl/pong_pkg.sv | 40 ++++
 rtl/ball_axis.sv | 69 ++++++
 rtl/ball_motion.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared constants for the ball motion block. Holds the
//               direction encoding, the controller state encoding and the
//               helper functions that size position and speed buses.
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Horizontal direction encoding
    localparam logic c_DIR_RIGHT = 1'b0;
    localparam logic c_DIR_LEFT  = 1'b1;

    // Vertical direction encoding
    localparam logic c_DIR_DOWN  = 1'b0;
    localparam logic c_DIR_UP    = 1'b1;

    // LEFT and UP share an encoding: both move the coordinate toward zero.
    // The axis helper relies on this to serve both axes.
    localparam logic c_DIR_TOWARD_ZERO = 1'b1;

    // Controller state encoding
    localparam int         c_STATE_W      = 2;
    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_MOVING    = 2'd1;
    localparam logic [1:0] c_ST_MISS_HOLD = 2'd2;

    // Bits needed for a coordinate in the range 0 .. extent-1
    function automatic int pos_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    // Bits needed to hold a speed value in the range 0 .. max_speed
    function automatic int speed_width(input int max_speed);
        return (max_speed > 0) ? $clog2(max_speed + 1) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ball_axis.sv
`default_nettype none
// ============================================================================
// Module      : ball_axis
// Description : Combinational step arithmetic for one ball axis. Advances a
//               coordinate by the current speed and clamps it to 0 or LIMIT,
//               and reports edge conditions used for bounce / hit decisions.
// Ports       : i_pos          current coordinate
//               i_dir          1 = toward 0 (LEFT/UP), 0 = toward LIMIT
//               i_speed        step size in pixels
//               o_next_pos     coordinate after one step, clamped
//               o_next_at_edge the step reached or passed the edge
//               o_at_edge      coordinate already sits on the edge it heads to
//               o_return_pos   coordinate after reflecting off that edge
// Revision    : 1.0 - initial release
// ============================================================================
module ball_axis
    import pong_pkg::*;
#(
    parameter int W     = 10,
    parameter int SW    = 3,
    parameter int LIMIT = 632
) (
    input  logic [W-1:0]  i_pos,
    input  logic          i_dir,
    input  logic [SW-1:0] i_speed,
    output logic [W-1:0]  o_next_pos,
    output logic          o_next_at_edge,
    output logic          o_at_edge,
    output logic [W-1:0]  o_return_pos
);

    localparam logic [W:0]   c_LIMIT_EXT = (W+1)'(LIMIT);
    localparam logic [W-1:0] c_LIMIT     = W'(LIMIT);

    // One extra bit so pos + speed never wraps before the comparison.
    logic [W:0] w_pos_ext;
    logic [W:0] w_spd_ext;
    logic [W:0] w_sum;

    assign w_pos_ext = {1'b0, i_pos};
    assign w_spd_ext = (W+1)'(i_speed);
    assign w_sum     = w_pos_ext + w_spd_ext;

    always_comb begin
        o_next_pos     = i_pos;
        o_next_at_edge = 1'b0;
        if (i_dir == c_DIR_TOWARD_ZERO) begin
            if (w_pos_ext <= w_spd_ext) begin
                o_next_pos     = '0;
                o_next_at_edge = 1'b1;
            end else begin
                o_next_pos = W'(w_pos_ext - w_spd_ext);
            end
        end else begin
            if (w_sum >= c_LIMIT_EXT) begin
                o_next_pos     = c_LIMIT;
                o_next_at_edge = 1'b1;
            end else begin
                o_next_pos = W'(w_sum);
            end
        end
    end

    assign o_at_edge    = (i_dir == c_DIR_TOWARD_ZERO) ? (i_pos == '0) : (i_pos == c_LIMIT);
    assign o_return_pos = (i_dir == c_DIR_TOWARD_ZERO) ? W'(w_spd_ext)
                                                       : W'(c_LIMIT_EXT - w_spd_ext);

endmodule
`default_nettype wire

// File: rtl/ball_motion.sv
`default_nettype none
// ============================================================================
// Module      : ball_motion
// Description : Pong ball controller. Serves the ball from the screen centre,
//               moves it once per frame tick, bounces it off the top and
//               bottom walls, returns it from latched paddle hits and holds
//               it after a miss before re-centring.
// Ports       : i_Clk, i_Reset          clock, synchronous active-high reset
//               i_Frame_Tick            one-cycle pulse per frame
//               i_Serve, i_Serve_Dir    start play from IDLE, initial hdir
//               i_Hit_Left/Right        paddle overlap, any cycle
//               i_Switch                debug direction override
//               o_Ball_X/Y              ball top-left position
//               o_HDir/o_VDir           RIGHT=0 LEFT=1 / DOWN=0 UP=1
//               o_Miss_Left/Right       one-cycle miss pulses
//               o_Speed, o_Rally        step size, hits in this rally
//               o_State                 IDLE=0 MOVING=1 MISS_HOLD=2
// Config      : define BALL_DEBUG_SWITCH_EN to enable the i_Switch override;
//               otherwise i_Switch is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module ball_motion
    import pong_pkg::*;
#(
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int BALL_SIZE     = 8,
    parameter int MAX_SPEED     = 4,
    parameter int HITS_PER_STEP = 4,
    parameter int HOLD_FRAMES   = 60
) (
    input  logic                                i_Clk,
    input  logic                                i_Reset,
    input  logic                                i_Frame_Tick,
    input  logic                                i_Serve,
    input  logic                                i_Serve_Dir,
    input  logic                                i_Hit_Left,
    input  logic                                i_Hit_Right,
    input  logic [3:0]                          i_Switch,
    output logic [pos_width(H_ACTIVE)-1:0]      o_Ball_X,
    output logic [pos_width(V_ACTIVE)-1:0]      o_Ball_Y,
    output logic                                o_HDir,
    output logic                                o_VDir,
    output logic                                o_Miss_Left,
    output logic                                o_Miss_Right,
    output logic [speed_width(MAX_SPEED)-1:0]   o_Speed,
    output logic [7:0]                          o_Rally,
    output logic [c_STATE_W-1:0]                o_State
);

    localparam int c_XW   = pos_width(H_ACTIVE);
    localparam int c_YW   = pos_width(V_ACTIVE);
    localparam int c_SW   = speed_width(MAX_SPEED);
    localparam int c_HW   = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam int c_XMAX = H_ACTIVE - BALL_SIZE;
    localparam int c_YMAX = V_ACTIVE - BALL_SIZE;

    localparam logic [c_XW-1:0] c_X_CENTRE  = c_XW'(c_XMAX / 2);
    localparam logic [c_YW-1:0] c_Y_CENTRE  = c_YW'(c_YMAX / 2);
    localparam logic [c_SW-1:0] c_SPEED_ONE = c_SW'(1);
    localparam logic [c_SW-1:0] c_SPEED_MAX = c_SW'(MAX_SPEED);
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_FRAMES - 1);
    localparam logic [7:0]      c_RALLY_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    logic [c_STATE_W-1:0] r_state;
    logic [c_XW-1:0]      r_x;
    logic [c_YW-1:0]      r_y;
    logic                 r_hdir;
    logic                 r_vdir;
    logic [c_SW-1:0]      r_speed;
    logic [7:0]           r_rally;
    logic                 r_hit_l;
    logic                 r_hit_r;
    logic                 r_miss_l;
    logic                 r_miss_r;
    logic [c_HW-1:0]      r_hold_cnt;

    // ------------------------------------------------------------------
    // Per-axis step arithmetic
    // ------------------------------------------------------------------
    logic [c_XW-1:0] w_x_next;
    logic            w_x_next_edge;
    logic            w_x_at_edge;
    logic [c_XW-1:0] w_x_return;
    logic [c_YW-1:0] w_y_next;
    logic            w_y_next_edge;
    logic            w_y_at_edge;
    logic [c_YW-1:0] w_y_return;

    ball_axis #(
        .W     (c_XW),
        .SW    (c_SW),
        .LIMIT (c_XMAX)
    ) u_axis_x (
        .i_pos          (r_x),
        .i_dir          (r_hdir),
        .i_speed        (r_speed),
        .o_next_pos     (w_x_next),
        .o_next_at_edge (w_x_next_edge),
        .o_at_edge      (w_x_at_edge),
        .o_return_pos   (w_x_return)
    );

    ball_axis #(
        .W     (c_YW),
        .SW    (c_SW),
        .LIMIT (c_YMAX)
    ) u_axis_y (
        .i_pos          (r_y),
        .i_dir          (r_vdir),
        .i_speed        (r_speed),
        .o_next_pos     (w_y_next),
        .o_next_at_edge (w_y_next_edge),
        .o_at_edge      (w_y_at_edge),
        .o_return_pos   (w_y_return)
    );

    // x clamps without reversing, so its arrival flag is not needed; y only
    // bounces, so its at-edge and return values are not needed.
    logic w_unused_axis;
    assign w_unused_axis = ^{w_x_next_edge, w_y_at_edge, w_y_return};

    // ------------------------------------------------------------------
    // Hit evaluation and rally / speed bookkeeping
    // ------------------------------------------------------------------
    // A hit arriving in the same cycle as the tick still counts.
    logic       w_hit_now;
    logic [7:0] w_rally_inc;
    logic       w_speed_up;

    assign w_hit_now   = (r_hdir == c_DIR_LEFT) ? (r_hit_l | i_Hit_Left)
                                                : (r_hit_r | i_Hit_Right);
    assign w_rally_inc = (r_rally == c_RALLY_MAX) ? r_rally : r_rally + 8'd1;
    // Speed steps only when the rally actually advanced onto a multiple.
    assign w_speed_up  = (r_rally != c_RALLY_MAX)
                      && ((int'(w_rally_inc) % HITS_PER_STEP) == 0)
                      && (r_speed < c_SPEED_MAX);

    // ------------------------------------------------------------------
    // Debug direction override
    // ------------------------------------------------------------------
`ifdef BALL_DEBUG_SWITCH_EN
    logic w_sw_active;
    logic w_sw_hdir;
    logic w_sw_vdir;

    // Highest set bit has priority.
    always_comb begin
        w_sw_active = |i_Switch;
        w_sw_hdir   = r_hdir;
        w_sw_vdir   = r_vdir;
        if (i_Switch[3]) begin
            w_sw_hdir = c_DIR_RIGHT;
            w_sw_vdir = c_DIR_DOWN;
        end else if (i_Switch[2]) begin
            w_sw_hdir = c_DIR_RIGHT;
            w_sw_vdir = c_DIR_UP;
        end else if (i_Switch[1]) begin
            w_sw_hdir = c_DIR_LEFT;
            w_sw_vdir = c_DIR_DOWN;
        end else if (i_Switch[0]) begin
            w_sw_hdir = c_DIR_LEFT;
            w_sw_vdir = c_DIR_UP;
        end
    end
`else
    logic w_unused_switch;
    assign w_unused_switch = ^i_Switch;
`endif

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            r_state    <= c_ST_IDLE;
            r_x        <= c_X_CENTRE;
            r_y        <= c_Y_CENTRE;
            r_hdir     <= c_DIR_RIGHT;
            r_vdir     <= c_DIR_UP;
            r_speed    <= c_SPEED_ONE;
            r_rally    <= 8'd0;
            r_hit_l    <= 1'b0;
            r_hit_r    <= 1'b0;
            r_miss_l   <= 1'b0;
            r_miss_r   <= 1'b0;
            r_hold_cnt <= '0;
        end else begin
            r_miss_l <= 1'b0;
            r_miss_r <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_hit_l <= 1'b0;
                    r_hit_r <= 1'b0;
                    if (i_Serve) begin
                        r_state <= c_ST_MOVING;
                        r_x     <= c_X_CENTRE;
                        r_y     <= c_Y_CENTRE;
                        r_hdir  <= i_Serve_Dir;
                        r_vdir  <= c_DIR_UP;
                        r_speed <= c_SPEED_ONE;
                        r_rally <= 8'd0;
                    end
                end

                c_ST_MOVING: begin
                    if (i_Frame_Tick) begin
                        // Vertical: move and bounce in the same tick.
                        r_y <= w_y_next;
                        if (w_y_next_edge) begin
                            r_vdir <= ~r_vdir;
                        end

                        // Horizontal: a ball resting on the edge it heads
                        // toward is returned by a hit or lost by a miss.
                        if (w_x_at_edge) begin
                            if (w_hit_now) begin
                                r_x     <= w_x_return;
                                r_hdir  <= ~r_hdir;
                                r_rally <= w_rally_inc;
                                if (w_speed_up) begin
                                    r_speed <= r_speed + c_SPEED_ONE;
                                end
                            end else begin
                                r_miss_l   <= (r_hdir == c_DIR_LEFT);
                                r_miss_r   <= (r_hdir == c_DIR_RIGHT);
                                r_state    <= c_ST_MISS_HOLD;
                                r_hold_cnt <= '0;
                            end
                        end else begin
                            r_x <= w_x_next;
                        end

                        r_hit_l <= 1'b0;
                        r_hit_r <= 1'b0;
                    end else begin
                        if (i_Hit_Left) begin
                            r_hit_l <= 1'b1;
                        end
                        if (i_Hit_Right) begin
                            r_hit_r <= 1'b1;
                        end
                    end
`ifdef BALL_DEBUG_SWITCH_EN
                    // Placed last so it wins over bounce and hit results.
                    if (w_sw_active) begin
                        r_hdir <= w_sw_hdir;
                        r_vdir <= w_sw_vdir;
                    end
`endif
                end

                c_ST_MISS_HOLD: begin
                    r_hit_l <= 1'b0;
                    r_hit_r <= 1'b0;
                    if (i_Frame_Tick) begin
                        if (r_hold_cnt == c_HOLD_LAST) begin
                            r_state    <= c_ST_IDLE;
                            r_x        <= c_X_CENTRE;
                            r_y        <= c_Y_CENTRE;
                            r_hdir     <= c_DIR_RIGHT;
                            r_vdir     <= c_DIR_UP;
                            r_speed    <= c_SPEED_ONE;
                            r_rally    <= 8'd0;
                            r_hold_cnt <= '0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_x     <= c_X_CENTRE;
                    r_y     <= c_Y_CENTRE;
                    r_hit_l <= 1'b0;
                    r_hit_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_Ball_X     = r_x;
    assign o_Ball_Y     = r_y;
    assign o_HDir       = r_hdir;
    assign o_VDir       = r_vdir;
    assign o_Miss_Left  = r_miss_l;
    assign o_Miss_Right = r_miss_r;
    assign o_Speed      = r_speed;
    assign o_Rally      = r_rally;
    assign o_State      = r_state;

endmodule
`default_nettype wire
